bin_pixel_packer: RTL
=====================

BIN_PIXEL_PACKER -- requirements
Module: bin_pixel_packer

Interface
REQ-001 Parameter WORD_W, default 16: number of binary pixels per output word.
REQ-002 Parameter FRAME_WORDS, default 19200: maximum words accepted per frame (640*480/16).
REQ-003 iCLK  input  1: single clock for all logic, the CCD pixel clock.
REQ-004 iRST  input  1: reset, asynchronous and active-high.
REQ-005 iEN  input  1: arm capture; sampled only while waiting for a frame start.
REQ-006 iDATA  input  12: raw pixel intensity from the colour-conversion stage.
REQ-007 iDVAL  input  1: iDATA valid this cycle.
REQ-008 iFVAL  input  1: frame valid from the capture stage.
REQ-009 iThreshold  input  10: binarisation threshold.
REQ-010 oDATA  output  WORD_W: packed word to the SDRAM write FIFO.
REQ-011 oDVAL  output  1: one-cycle strobe, oDATA valid.
REQ-012 oWord_Cont  output  16: words emitted in the current frame.
REQ-013 oFrame_Done  output  1: one-cycle pulse at end of frame.
REQ-014 oOverflow  output  1: sticky, frame exceeded FRAME_WORDS.
REQ-015 oBusy  output  1: high in ARMED, ACTIVE or FLUSH.

Function
REQ-016 Pixel bit SHALL be 1 when iDATA[11:2] >= iThreshold, else 0 (unsigned compare).
REQ-017 Packing SHALL be first-accepted pixel in bit 0, k-th pixel in bit k-1.
REQ-018 FSM states SHALL be IDLE, ARMED, ACTIVE, FLUSH.
REQ-019 IDLE -> ARMED when iEN=1; otherwise stay.
REQ-020 ARMED -> ACTIVE on iFVAL rising edge (registered previous iFVAL=0, current=1); this clears oWord_Cont, bit counter, shift register and oOverflow.
REQ-021 A pixel SHALL be accepted only in ACTIVE with iDVAL=1, including the cycle in which iFVAL rises and the cycle in which iFVAL falls.
REQ-022 When the WORD_W-th pixel is accepted, oDATA and oDVAL=1 SHALL be registered on the next edge: latency one cycle; bit counter returns to 0.
REQ-023 oWord_Cont SHALL increment with each oDVAL and saturate at FRAME_WORDS.
REQ-024 If oWord_Cont = FRAME_WORDS, further pixels SHALL be dropped, oOverflow set, and no oDVAL generated.
REQ-025 On iFVAL falling edge in ACTIVE: go to FLUSH if bit counter is nonzero after that cycle's accept; otherwise go to IDLE and pulse oFrame_Done next cycle.
REQ-026 FLUSH SHALL emit the partial word zero-padded in the unfilled high bits for one cycle (oDVAL=1), pulse oFrame_Done the same cycle, and go to IDLE.
REQ-027 A FLUSH word SHALL be suppressed if oWord_Cont = FRAME_WORDS; oOverflow is then set and oFrame_Done still pulses.
REQ-028 A full word completing on the iFVAL-fall cycle SHALL be emitted normally with no extra flush word.
REQ-029 iEN deasserted during ACTIVE SHALL NOT abort the frame; it only prevents re-arming from IDLE.
REQ-030 oDVAL and oFrame_Done SHALL never be high for two consecutive cycles from one event.

Reset
REQ-031 iRST=1 SHALL immediately force state IDLE and oDATA=0, oDVAL=0, oWord_Cont=0, oFrame_Done=0, oOverflow=0, oBusy=0, bit counter=0.
REQ-032 Reset mid-frame SHALL discard the partial word with no flush; after release, the block needs iEN and a fresh iFVAL rise before accepting pixels.

Verification
REQ-033 Threshold=512, iEN=1, frame of 32 valid pixels alternating iDATA=0xFFF/0x000 -> two oDVAL strobes with oDATA=0x5555 each, oWord_Cont=2, oFrame_Done pulses once with no flush.
REQ-034 Frame of 20 pixels, all 0xFFF, threshold 0 -> words 0xFFFF then 0x000F from FLUSH, with oFrame_Done coincident with the second strobe.
REQ-035 FRAME_WORDS=2, 48 pixels -> exactly 2 strobes, oOverflow=1 after the third word would complete, oWord_Cont holds 2, oOverflow clears on next frame start.
REQ-036 iFVAL already high when iEN rises -> no pixels accepted until iFVAL falls and rises again.
REQ-037 iRST pulsed after 7 pixels -> all outputs 0 asynchronously, no flush word; next full frame packs from bit 0.
REQ-038 16th pixel on the same cycle iFVAL falls -> single oDVAL with full word, oFrame_Done one cycle later, FLUSH not entered.

Source files
------------

// File: rtl/bin_pixel_packer.sv
// bin_pixel_packer: thresholds camera pixels to 1 bit and packs WORD_W of them per output word, frame-gated
module bin_pixel_packer #(
    parameter int WORD_W      = 16,
    parameter int FRAME_WORDS = 19200
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iEN,
    input  logic [11:0]       iDATA,
    input  logic              iDVAL,
    input  logic              iFVAL,
    input  logic [9:0]        iThreshold,
    output logic [WORD_W-1:0] oDATA,
    output logic              oDVAL,
    output logic [15:0]       oWord_Cont,
    output logic              oFrame_Done,
    output logic              oOverflow,
    output logic              oBusy
);
    localparam int CW = WORD_W > 1 ? $clog2(WORD_W) : 1;
    typedef enum logic [1:0] {IDLE, ARMED, ACTIVE, FLUSH} state_t;
    state_t state, state_n;
    logic fval_d, rise, fall, clr, acc, full, pix;
    logic dval_n, fd_n, ovf_b, ovf_n;
    logic [CW-1:0] bit_cnt, cnt_b, cnt_n;
    logic [WORD_W-1:0] sr, sr_b, sr_n, data_n;
    logic [15:0] wc_b, wc_n;
    assign pix = iDATA[11:2] >= iThreshold;
    assign rise = iFVAL & ~fval_d;
    assign fall = ~iFVAL & fval_d;
    assign oBusy = state != IDLE;
    // state register
    always_ff @(posedge iCLK or posedge iRST)
        if (iRST) state <= IDLE;
        else state <= state_n;
    // datapath and output registers; a frame start clears the per-frame state through the *_b terms
    always_ff @(posedge iCLK or posedge iRST)
        if (iRST) begin
            fval_d      <= 1'b0;
            bit_cnt     <= '0;
            sr          <= '0;
            oDATA       <= '0;
            oDVAL       <= 1'b0;
            oWord_Cont  <= '0;
            oFrame_Done <= 1'b0;
            oOverflow   <= 1'b0;
        end else begin
            fval_d      <= iFVAL;
            bit_cnt     <= cnt_n;
            sr          <= sr_n;
            oDATA       <= data_n;
            oDVAL       <= dval_n;
            oWord_Cont  <= wc_n;
            oFrame_Done <= fd_n;
            oOverflow   <= ovf_n;
        end
    // next state, pixel accept/pack, word emission and saturation
    always_comb begin
        state_n = state;
        clr     = (state == ARMED) && rise;
        cnt_b   = clr ? '0 : bit_cnt;
        sr_b    = clr ? '0 : sr;
        wc_b    = clr ? '0 : oWord_Cont;
        ovf_b   = clr ? 1'b0 : oOverflow;
        full    = wc_b == 16'(FRAME_WORDS);
        acc     = ((state == ACTIVE) || clr) && iDVAL;
        cnt_n   = cnt_b;
        sr_n    = sr_b;
        data_n  = oDATA;
        dval_n  = 1'b0;
        wc_n    = wc_b;
        ovf_n   = ovf_b;
        fd_n    = 1'b0;
        if (acc) begin
            sr_n[cnt_b] = pix;
            cnt_n = cnt_b + CW'(1);
            if (cnt_b == CW'(WORD_W - 1)) begin
                cnt_n  = '0;
                data_n = full ? oDATA : sr_n;
                dval_n = !full;
                wc_n   = full ? wc_b : wc_b + 16'd1;
                ovf_n  = ovf_b | full;
                sr_n   = '0;
            end
        end
        case (state)
            IDLE:   state_n = iEN ? ARMED : IDLE;
            ARMED:  state_n = rise ? ACTIVE : ARMED;
            ACTIVE: if (fall) begin
                state_n = cnt_n != '0 ? FLUSH : IDLE;
                fd_n    = cnt_n == '0;
            end
            FLUSH: begin
                state_n = IDLE;
                fd_n    = 1'b1;
                dval_n  = !full;
                data_n  = full ? oDATA : sr;
                wc_n    = full ? wc_b : wc_b + 16'd1;
                ovf_n   = ovf_b | full;
                cnt_n   = '0;
                sr_n    = '0;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
